data_writeback: RTL and testbench

- Write-side counterpart of the operand fetch stage.
- Accepts results from the execute unit (valid, result register number, result word, halt) and commits them to the data memory write port through a small in-order write buffer.
- Exposes pending-write hazard checks to the fetch side.
- On halt, drains all pending writes, then reports completion to the top level.

---
 rtl/data_writeback_if.sv | 39 +++
 rtl/data_writeback.sv | 105 ++++++++++
 tb/tb_data_writeback.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_writeback_if.sv
// Execute-to-writeback bus: result input, data memory write port,
// fetch-side hazard probes and status flags.
interface data_writeback_if #(
    parameter int unsigned WORDSZ   = 32,
    parameter int unsigned RFSZLOG2 = 9
);
    logic                ex_valid;
    logic [RFSZLOG2-1:0] rn_ex;
    logic [WORDSZ-1:0]   res_ex;
    logic                halt_ex;

    logic                wen_dm;
    logic [RFSZLOG2-1:0] waddr_dm;
    logic [WORDSZ-1:0]   wdata_dm;
    logic                wack_dm;

    logic [RFSZLOG2-1:0] chk_addr_0;
    logic [RFSZLOG2-1:0] chk_addr_1;
    logic                chk_hit_0;
    logic                chk_hit_1;

    logic                buf_full;
    logic                ovf_err;
    logic                halt_done;

    // Execute / memory / fetch environment side
    modport master (
        output ex_valid, rn_ex, res_ex, halt_ex, wack_dm, chk_addr_0, chk_addr_1,
        input  wen_dm, waddr_dm, wdata_dm, chk_hit_0, chk_hit_1,
        input  buf_full, ovf_err, halt_done
    );

    // Writeback stage side
    modport slave (
        input  ex_valid, rn_ex, res_ex, halt_ex, wack_dm, chk_addr_0, chk_addr_1,
        output wen_dm, waddr_dm, wdata_dm, chk_hit_0, chk_hit_1,
        output buf_full, ovf_err, halt_done
    );
endinterface

// File: rtl/data_writeback.sv
// Writeback stage: in-order write buffer in front of the data memory write
// port, pending-write hazard probes for fetch, and halt drain sequencing.
module data_writeback #(
    parameter int unsigned WORDSZ   = 32,
    parameter int unsigned RFSZLOG2 = 9,
    parameter int unsigned DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    data_writeback_if.slave  bus
);
    localparam int unsigned PTRW = $clog2(DEPTH);
    localparam int unsigned CNTW = PTRW + 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [RFSZLOG2-1:0] addr_q [DEPTH];
    logic [WORDSZ-1:0]   data_q [DEPTH];
    logic [DEPTH-1:0]    vld_q;
    logic [PTRW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [CNTW-1:0]     count_q, count_d;
    logic                wen_q, full_q, ovf_q, done_q;
    logic                ovf_d;
    logic                enq_req, enq, deq;
    logic                hit_0, hit_1;

    // Enqueue/dequeue decisions, occupancy and halt sequencing for the next edge
    always_comb begin
        deq     = wen_q & bus.wack_dm;
        enq_req = bus.ex_valid && (bus.rn_ex != '0) && (state_q == RUN) && !bus.halt_ex;
        enq     = enq_req && (!full_q || deq);
        ovf_d   = ovf_q | (enq_req & full_q & ~deq);
        count_d = count_q + CNTW'(enq) - CNTW'(deq);
        state_d = state_q;
        case (state_q)
            RUN:     if (bus.halt_ex) state_d = DRAIN;
            DRAIN:   if ((count_q == '0) || ((count_q == CNTW'(1)) && deq)) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    // Pending-write probes: occupied entries plus the result arriving this cycle
    always_comb begin
        hit_0 = bus.ex_valid && (bus.rn_ex == bus.chk_addr_0);
        hit_1 = bus.ex_valid && (bus.rn_ex == bus.chk_addr_1);
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (addr_q[i] == bus.chk_addr_0)) hit_0 = 1'b1;
            if (vld_q[i] && (addr_q[i] == bus.chk_addr_1)) hit_1 = 1'b1;
        end
        hit_0 = hit_0 && (bus.chk_addr_0 != '0);
        hit_1 = hit_1 && (bus.chk_addr_1 != '0);
    end

    // Buffer storage, pointers, halt FSM and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            vld_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= RUN;
            wen_q    <= 1'b0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // Clear before set so a full-buffer pass-through keeps the slot valid
            if (deq) begin
                vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= rd_ptr_q + PTRW'(1);
            end
            if (enq) begin
                addr_q[wr_ptr_q] <= bus.rn_ex;
                data_q[wr_ptr_q] <= bus.res_ex;
                vld_q[wr_ptr_q]  <= 1'b1;
                wr_ptr_q         <= wr_ptr_q + PTRW'(1);
            end
            count_q <= count_d;
            state_q <= state_d;
            wen_q   <= (count_d != '0);
            full_q  <= (count_d == CNTW'(DEPTH));
            ovf_q   <= ovf_d;
            done_q  <= (state_d == DONE);
        end
    end

    assign bus.wen_dm    = wen_q;
    assign bus.waddr_dm  = addr_q[rd_ptr_q];
    assign bus.wdata_dm  = data_q[rd_ptr_q];
    assign bus.buf_full  = full_q;
    assign bus.ovf_err   = ovf_q;
    assign bus.halt_done = done_q;
    assign bus.chk_hit_0 = hit_0;
    assign bus.chk_hit_1 = hit_1;
endmodule

// File: tb/tb_data_writeback.sv
// Bench for data_writeback: scoreboard of expected memory writes plus
// per-scenario tasks checking latency, full/overflow, hazards and halt.
module tb_data_writeback;
    localparam int unsigned WORDSZ   = 32;
    localparam int unsigned RFSZLOG2 = 9;
    localparam int unsigned DEPTH    = 4;

    typedef struct packed {
        logic [RFSZLOG2-1:0] a;
        logic [WORDSZ-1:0]   d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    wr_t  sb[$];

    data_writeback_if #(.WORDSZ(WORDSZ), .RFSZLOG2(RFSZLOG2)) bus ();

    data_writeback #(.WORDSZ(WORDSZ), .RFSZLOG2(RFSZLOG2), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Every committed write must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && bus.wen_dm && bus.wack_dm) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL commit_unexpected: wrote addr=%0d data=%h, required no write",
                         bus.waddr_dm, bus.wdata_dm);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if (bus.waddr_dm !== e.a || bus.wdata_dm !== e.d) begin
                    errors++;
                    $display("FAIL commit_order: got addr=%0d data=%h, required addr=%0d data=%h",
                             bus.waddr_dm, bus.wdata_dm, e.a, e.d);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ex_valid   = 1'b0;
        bus.rn_ex      = '0;
        bus.res_ex     = '0;
        bus.halt_ex    = 1'b0;
        bus.chk_addr_0 = '0;
        bus.chk_addr_1 = '0;
    endtask

    task automatic drive_ex(input logic v, input int a, input logic [WORDSZ-1:0] d);
        bus.ex_valid = v;
        bus.rn_ex    = RFSZLOG2'(a);
        bus.res_ex   = d;
    endtask

    task automatic apply_reset();
        idle_inputs();
        bus.wack_dm = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        step();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d writes outstanding, required 0", name, sb.size());
        end
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.wack_dm    = 1'b1;
        bus.chk_addr_0 = 9'd5;
        rst = 1'b1;
        #3;
        checks++;
        if ({bus.wen_dm, bus.buf_full, bus.ovf_err, bus.halt_done, bus.chk_hit_0} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: wen/full/ovf/done/hit=%b, required 00000",
                     {bus.wen_dm, bus.buf_full, bus.ovf_err, bus.halt_done, bus.chk_hit_0});
        end
        checks++;
        if (bus.waddr_dm !== '0 || bus.wdata_dm !== '0) begin
            errors++;
            $display("FAIL reset_bus: waddr=%0d wdata=%h, required 0/0", bus.waddr_dm, bus.wdata_dm);
        end
        apply_reset();
    endtask

    task automatic test_single_write();
        wr_t e;
        bus.wack_dm    = 1'b1;
        bus.chk_addr_0 = 9'd5;
        drive_ex(1'b1, 5, 32'h1234);
        e.a = 9'd5; e.d = 32'h1234; sb.push_back(e);
        @(negedge clk);
        checks++;
        if (bus.wen_dm !== 1'b0 || bus.chk_hit_0 !== 1'b1) begin
            errors++;
            $display("FAIL single_T: wen=%b hit0=%b, required wen=0 hit0=1", bus.wen_dm, bus.chk_hit_0);
        end
        step();
        drive_ex(1'b0, 0, '0);
        @(negedge clk);
        checks++;
        if (bus.wen_dm !== 1'b1 || bus.waddr_dm !== 9'd5 || bus.wdata_dm !== 32'h1234 || bus.chk_hit_0 !== 1'b1) begin
            errors++;
            $display("FAIL single_T1: wen=%b addr=%0d data=%h hit0=%b, required 1/5/00001234/1",
                     bus.wen_dm, bus.waddr_dm, bus.wdata_dm, bus.chk_hit_0);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.wen_dm !== 1'b0 || bus.chk_hit_0 !== 1'b0) begin
            errors++;
            $display("FAIL single_T2: wen=%b hit0=%b, required 0/0", bus.wen_dm, bus.chk_hit_0);
        end
        step();
    endtask

    task automatic test_nop();
        bus.wack_dm    = 1'b1;
        bus.chk_addr_0 = '0;
        drive_ex(1'b1, 0, 32'hFFFF);
        @(negedge clk);
        checks++;
        if (bus.chk_hit_0 !== 1'b0) begin
            errors++;
            $display("FAIL nop_hit: hit0=%b, required 0", bus.chk_hit_0);
        end
        step();
        drive_ex(1'b0, 0, '0);
        @(negedge clk);
        checks++;
        if (bus.wen_dm !== 1'b0 || bus.ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL nop_drop: wen=%b ovf=%b, required 0/0", bus.wen_dm, bus.ovf_err);
        end
        step();
    endtask

    task automatic test_full_overflow();
        wr_t e;
        apply_reset();
        bus.wack_dm = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive_ex(1'b1, i, WORDSZ'(32'hA000 + i));
            if (i <= 4) begin
                e.a = RFSZLOG2'(i); e.d = WORDSZ'(32'hA000 + i); sb.push_back(e);
            end
            @(negedge clk);
            if (i == 5) begin
                checks++;
                if (bus.buf_full !== 1'b1 || bus.ovf_err !== 1'b0) begin
                    errors++;
                    $display("FAIL full_after4: full=%b ovf=%b, required 1/0", bus.buf_full, bus.ovf_err);
                end
            end
            step();
        end
        drive_ex(1'b0, 0, '0);
        bus.chk_addr_0 = 9'd3;
        bus.chk_addr_1 = 9'd5;
        @(negedge clk);
        checks++;
        if (bus.ovf_err !== 1'b1 || bus.buf_full !== 1'b1 || bus.waddr_dm !== 9'd1) begin
            errors++;
            $display("FAIL overflow: ovf=%b full=%b head=%0d, required 1/1/1",
                     bus.ovf_err, bus.buf_full, bus.waddr_dm);
        end
        checks++;
        if (bus.chk_hit_0 !== 1'b1 || bus.chk_hit_1 !== 1'b0) begin
            errors++;
            $display("FAIL full_hazard: hit0(3)=%b hit1(5)=%b, required 1/0", bus.chk_hit_0, bus.chk_hit_1);
        end
        step();
        bus.wack_dm = 1'b1;
        wait_drain("full_drain", 20);
        @(negedge clk);
        checks++;
        if (bus.wen_dm !== 1'b0 || bus.buf_full !== 1'b0 || bus.ovf_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: wen=%b full=%b ovf=%b, required 0/0/1",
                     bus.wen_dm, bus.buf_full, bus.ovf_err);
        end
        step();
    endtask

    task automatic test_back_to_back();
        wr_t e;
        apply_reset();
        bus.wack_dm = 1'b0;
        for (int i = 10; i <= 13; i++) begin
            drive_ex(1'b1, i, WORDSZ'(32'hB000 + i));
            e.a = RFSZLOG2'(i); e.d = WORDSZ'(32'hB000 + i); sb.push_back(e);
            step();
        end
        bus.wack_dm = 1'b1;
        drive_ex(1'b1, 7, 32'hC0DE);
        e.a = 9'd7; e.d = 32'hC0DE; sb.push_back(e);
        @(negedge clk);
        checks++;
        if (bus.buf_full !== 1'b1 || bus.wen_dm !== 1'b1 || bus.waddr_dm !== 9'd10) begin
            errors++;
            $display("FAIL b2b_full: full=%b wen=%b head=%0d, required 1/1/10",
                     bus.buf_full, bus.wen_dm, bus.waddr_dm);
        end
        step();
        bus.wack_dm = 1'b0;
        drive_ex(1'b0, 0, '0);
        @(negedge clk);
        checks++;
        if (bus.buf_full !== 1'b1 || bus.ovf_err !== 1'b0 || bus.waddr_dm !== 9'd11) begin
            errors++;
            $display("FAIL b2b_pass: full=%b ovf=%b head=%0d, required 1/0/11",
                     bus.buf_full, bus.ovf_err, bus.waddr_dm);
        end
        step();
        bus.wack_dm = 1'b1;
        wait_drain("b2b_drain", 20);
    endtask

    task automatic test_halt_drain();
        wr_t e;
        int last_deq, done_at, ndeq;
        apply_reset();
        bus.wack_dm = 1'b0;
        for (int i = 20; i <= 22; i++) begin
            drive_ex(1'b1, i, WORDSZ'(32'hD000 + i));
            e.a = RFSZLOG2'(i); e.d = WORDSZ'(32'hD000 + i); sb.push_back(e);
            step();
        end
        drive_ex(1'b1, 9, 32'h9999);
        bus.halt_ex = 1'b1;
        step();
        bus.halt_ex = 1'b0;
        last_deq = -1; done_at = -1; ndeq = 0;
        for (int i = 0; i < 20; i++) begin
            bus.wack_dm = (i % 2 == 0);
            drive_ex(i == 1, 31, 32'h3131);
            bus.halt_ex = (i == 3);
            @(negedge clk);
            if (bus.wen_dm && bus.wack_dm) begin
                last_deq = i;
                ndeq++;
            end
            if (bus.halt_done && done_at < 0) done_at = i;
            step();
        end
        idle_inputs();
        checks++;
        if (ndeq != 3 || last_deq < 0 || done_at != last_deq + 1) begin
            errors++;
            $display("FAIL halt_drain: deqs=%0d last_deq=%0d done_at=%0d, required 3 deqs and done_at=last_deq+1",
                     ndeq, last_deq, done_at);
        end
        bus.wack_dm = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.halt_done !== 1'b1 || bus.wen_dm !== 1'b0 || bus.ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL halt_hold: done=%b wen=%b ovf=%b, required 1/0/0",
                     bus.halt_done, bus.wen_dm, bus.ovf_err);
        end
        step();
    endtask

    task automatic test_halt_empty();
        logic [2:0] seen;
        apply_reset();
        bus.halt_ex = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen[i] = bus.halt_done;
            step();
            bus.halt_ex = 1'b0;
        end
        checks++;
        if (seen !== 3'b100) begin
            errors++;
            $display("FAIL halt_empty: done at T,T+1,T+2=%b%b%b, required 001",
                     seen[0], seen[1], seen[2]);
        end
    endtask

    task automatic test_reset_mid_drain();
        wr_t e;
        apply_reset();
        bus.wack_dm = 1'b0;
        for (int i = 40; i <= 44; i++) begin
            drive_ex(1'b1, i, WORDSZ'(32'hE000 + i));
            if (i <= 43) begin
                e.a = RFSZLOG2'(i); e.d = WORDSZ'(32'hE000 + i); sb.push_back(e);
            end
            step();
        end
        drive_ex(1'b0, 0, '0);
        bus.wack_dm = 1'b1;
        repeat (2) step();
        bus.wack_dm = 1'b0;
        bus.halt_ex = 1'b1;
        step();
        bus.halt_ex = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.wen_dm !== 1'b1 || bus.ovf_err !== 1'b1 || bus.halt_done !== 1'b0 || sb.size() != 2) begin
            errors++;
            $display("FAIL pre_reset: wen=%b ovf=%b done=%b pending=%0d, required 1/1/0/2",
                     bus.wen_dm, bus.ovf_err, bus.halt_done, sb.size());
        end
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        checks++;
        if (bus.wen_dm !== 1'b0 || bus.halt_done !== 1'b0 || bus.ovf_err !== 1'b0 || bus.buf_full !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: wen=%b done=%b ovf=%b full=%b, required 0/0/0/0",
                     bus.wen_dm, bus.halt_done, bus.ovf_err, bus.buf_full);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.wack_dm = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            @(negedge clk);
            checks++;
            if (bus.wen_dm !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_write: cycle %0d wen=%b, required 0", i, bus.wen_dm);
            end
        end
    endtask

    initial begin
        idle_inputs();
        bus.wack_dm = 1'b0;
        test_reset();
        test_single_write();
        test_nop();
        test_full_overflow();
        test_back_to_back();
        test_halt_drain();
        test_halt_empty();
        test_reset_mid_drain();
        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
